// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch button front end
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Coming out of reset as if the button were held means a press
    // in progress at reset can never produce an impulse.
    localparam btn_state_t BTN_RESET_STATE = PRESSED;

    localparam int unsigned DEBOUNCE_MIN = 2;
    localparam int unsigned DEBOUNCE_MAX = 65535;

    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        return (cycles < DEBOUNCE_MIN) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_pulser_if.sv
// rtl/button_pulser_if.sv - raw button inputs and debounced impulse outputs
interface button_pulser_if;

    logic btn_start_stop;
    logic btn_lap;
    logic start_stop;
    logic lap_time;

    modport master (
        output btn_start_stop,
        output btn_lap,
        input  start_stop,
        input  lap_time
    );

    modport slave (
        input  btn_start_stop,
        input  btn_lap,
        output start_stop,
        output lap_time
    );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one button channel: synchronizer, debounce FSM, impulse register
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic res,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_s;
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_next;

    always_ff @(posedge clk) begin
        if (res) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_s    <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state <= BTN_RESET_STATE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
        end
    end

    // The counter leaves each wait state at CNT_LAST, so it cannot wrap.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        pulse_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync_s) begin
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!sync_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_s) begin
                    state_next = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (sync_s) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = BTN_RESET_STATE;
            end
        endcase
    end

endmodule

// File: rtl/button_pulser.sv
// rtl/button_pulser.sv - two independent debounced impulse channels for the stopwatch buttons
module button_pulser
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic           clk,
    input  logic           res,
    button_pulser_if.slave bus
);

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_stop (
        .clk  (clk),
        .res  (res),
        .btn  (bus.btn_start_stop),
        .pulse(bus.start_stop)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lap (
        .clk  (clk),
        .res  (res),
        .btn  (bus.btn_lap),
        .pulse(bus.lap_time)
    );

endmodule
